// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding and
// elaboration-time helpers used to size the sequencer's single counter.
// No ports; imported by pll_reset_sequencer.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bit_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit.
// Latency: q_o follows d_i after 2 clk_i edges; no backpressure (free-running).
// Ports: clk_i destination clock, rst_ni async active-low reset (q_o -> 0),
//        d_i asynchronous input, q_o synchronized output.
module bit_sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for stable lock, then
// releases the downstream system reset; re-resets the PLL on lock loss/timeout.
// Latency: lock seen 2 edges after pll_locked (sync) + 1 FSM edge; no backpressure.
// Ports: clk/reset_n (refclk domain, async active-low reset), pll_locked (async),
//        sw_restart (1-cycle request), pll_rst, sys_reset_n, lock_lost,
//        retry_count (saturating), state (FSM readback).
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES          = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int RETRY_W             = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               sw_restart,
  output logic               pll_rst,
  output logic               sys_reset_n,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count,
  output logic [1:0]         state
);

  localparam int CNT_W = clog2(max3(RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES)) + 1;

  // Terminal counts: the counter starts at 0 on state entry, so value N-1
  // marks the Nth cycle spent in the state.
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  logic locked_s;

  seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_reset_n_q, sys_reset_n_d;
  logic               lock_lost_q, lock_lost_d;
  logic               retry_evt;

  bit_sync_2ff u_lock_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (pll_locked),
    .q_o    (locked_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    retry_d     = retry_q;
    lock_lost_d = 1'b0;
    retry_evt   = 1'b0;

    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock is tested first so a lock arriving on the timeout cycle wins.
        if (locked_s) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = PLL_RST;
          retry_evt = 1'b1;
        end
      end
      STABLE: begin
        // A single low cycle restarts the lock wait; it is not a retry.
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q;  // hold: RUN is unbounded and must not wrap
        if (!locked_s) begin
          state_d     = PLL_RST;
          retry_evt   = 1'b1;
          lock_lost_d = 1'b1;
        end
      end
    endcase

    // Software restart overrides everything, including a simultaneous lock
    // loss, and also restarts the reset pulse if already in PLL_RST.
    if (sw_restart) begin
      state_d     = PLL_RST;
      retry_evt   = 1'b0;
      lock_lost_d = 1'b0;
    end

    if ((state_d != state_q) || sw_restart) cnt_d = '0;

    if (retry_evt && (retry_q != '1)) retry_d = retry_q + 1'b1;

    // Outputs are decoded from the next state so they change on the same
    // edge as the state register and come straight from flops.
    pll_rst_d     = (state_d == PLL_RST);
    sys_reset_n_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= PLL_RST;
      cnt_q         <= '0;
      retry_q       <= '0;
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      pll_rst_q     <= pll_rst_d;
      sys_reset_n_q <= sys_reset_n_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_reset_n = sys_reset_n_q;
  assign lock_lost   = lock_lost_q;
  assign retry_count = retry_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer (RST=4, STABLE=8, TIMEOUT=32, RETRY_W=2).
// Stimulus pushes expected output snapshots (with the cycle they must appear);
// a monitor pops and compares each time the DUT's outputs change.
module tb_pll_reset_sequencer;

  typedef struct {
    int         cyc;
    logic [1:0] st;
    logic       prst;
    logic       sysn;
    logic       ll;
    logic [1:0] rc;
  } ev_t;

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       sw_restart;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       lock_lost;
  logic [1:0] retry_count;
  logic [1:0] state;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  ev_idx = 0;
  bit  mon_en = 1'b0;
  ev_t exp_q[$];

  pll_reset_sequencer #(
    .RST_CYCLES          (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .RETRY_W             (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .sw_restart  (sw_restart),
    .pll_rst     (pll_rst),
    .sys_reset_n (sys_reset_n),
    .lock_lost   (lock_lost),
    .retry_count (retry_count),
    .state       (state)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [1:0] s, input logic p,
                      input logic sn, input logic l, input logic [1:0] r);
    ev_t e;
    e.cyc = c; e.st = s; e.prst = p; e.sysn = sn; e.ll = l; e.rc = r;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic snap(output ev_t g);
    g.cyc = cyc; g.st = state; g.prst = pll_rst; g.sysn = sys_reset_n;
    g.ll = lock_lost; g.rc = retry_count;
  endtask

  task automatic compare_ev(input ev_t g);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL ev%0d unexpected: got cyc=%0d st=%0d prst=%0b sysn=%0b ll=%0b rc=%0d, required none",
               ev_idx, g.cyc, g.st, g.prst, g.sysn, g.ll, g.rc);
    end else begin
      e = exp_q.pop_front();
      if (g.cyc != e.cyc || g.st !== e.st || g.prst !== e.prst || g.sysn !== e.sysn ||
          g.ll !== e.ll || g.rc !== e.rc) begin
        errors++;
        $display("FAIL ev%0d: got cyc=%0d st=%0d prst=%0b sysn=%0b ll=%0b rc=%0d, required cyc=%0d st=%0d prst=%0b sysn=%0b ll=%0b rc=%0d",
                 ev_idx, g.cyc, g.st, g.prst, g.sysn, g.ll, g.rc,
                 e.cyc, e.st, e.prst, e.sysn, e.ll, e.rc);
      end
    end
    ev_idx++;
  endtask

  // Monitor: one comparison per distinct output snapshot.
  initial begin
    ev_t got;
    ev_t last;
    wait (mon_en);
    snap(got);
    compare_ev(got);
    last = got;
    forever begin
      @(state or pll_rst or sys_reset_n or lock_lost or retry_count);
      #1;
      snap(got);
      if (got.st !== last.st || got.prst !== last.prst || got.sysn !== last.sysn ||
          got.ll !== last.ll || got.rc !== last.rc) begin
        compare_ev(got);
      end
      last = got;
    end
  end

  initial begin
    int b;
    reset_n    = 1'b1;
    pll_locked = 1'b0;
    sw_restart = 1'b0;
    #5 reset_n = 1'b0;
    #1;
    push(cyc, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);  // reset values
    mon_en = 1'b1;

    // Power-up: 4-cycle PLL reset, lock 10 cycles after release, 8 stable.
    tick(3);
    b = cyc;
    reset_n = 1'b1;
    push(b + 4, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0);
    tick(10);
    b = cyc;
    pll_locked = 1'b1;
    push(b + 3,  2'd2, 1'b0, 1'b0, 1'b0, 2'd0);
    push(b + 11, 2'd3, 1'b0, 1'b1, 1'b0, 2'd0);
    tick(15);

    // Lock loss in RUN, then relock.
    b = cyc;
    pll_locked = 1'b0;
    push(b + 3, 2'd0, 1'b1, 1'b0, 1'b1, 2'd1);
    push(b + 4, 2'd0, 1'b1, 1'b0, 1'b0, 2'd1);
    push(b + 7, 2'd1, 1'b0, 1'b0, 1'b0, 2'd1);
    tick(10);
    b = cyc;
    pll_locked = 1'b1;
    push(b + 3,  2'd2, 1'b0, 1'b0, 1'b0, 2'd1);
    push(b + 11, 2'd3, 1'b0, 1'b1, 1'b0, 2'd1);
    tick(15);

    // sw_restart on the same edge the FSM sees lock loss in RUN.
    b = cyc;
    pll_locked = 1'b0;
    push(b + 3, 2'd0, 1'b1, 1'b0, 1'b0, 2'd1);
    push(b + 7, 2'd1, 1'b0, 1'b0, 1'b0, 2'd1);
    tick(2);
    sw_restart = 1'b1;
    tick(1);
    sw_restart = 1'b0;
    // Lock becomes visible exactly on the timeout edge (b+39): lock wins.
    tick(33);
    b = cyc;
    pll_locked = 1'b1;
    push(b + 3,  2'd2, 1'b0, 1'b0, 1'b0, 2'd1);
    push(b + 11, 2'd3, 1'b0, 1'b1, 1'b0, 2'd1);
    tick(14);

    // sw_restart alone from RUN, then a one-cycle glitch during STABLE.
    b = cyc;
    pll_locked = 1'b0;
    sw_restart = 1'b1;
    push(b + 1, 2'd0, 1'b1, 1'b0, 1'b0, 2'd1);
    push(b + 5, 2'd1, 1'b0, 1'b0, 1'b0, 2'd1);
    tick(1);
    sw_restart = 1'b0;
    tick(9);
    pll_locked = 1'b1;
    push(b + 13, 2'd2, 1'b0, 1'b0, 1'b0, 2'd1);
    push(b + 18, 2'd1, 1'b0, 1'b0, 1'b0, 2'd1);
    push(b + 19, 2'd2, 1'b0, 1'b0, 1'b0, 2'd1);
    push(b + 27, 2'd3, 1'b0, 1'b1, 1'b0, 2'd1);
    tick(5);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(14);

    // Lock never arrives: timeouts every 4+32 cycles, retry saturates at 3.
    b = cyc;
    pll_locked = 1'b0;
    sw_restart = 1'b1;
    push(b + 1,   2'd0, 1'b1, 1'b0, 1'b0, 2'd1);
    push(b + 5,   2'd1, 1'b0, 1'b0, 1'b0, 2'd1);
    push(b + 37,  2'd0, 1'b1, 1'b0, 1'b0, 2'd2);
    push(b + 41,  2'd1, 1'b0, 1'b0, 1'b0, 2'd2);
    push(b + 73,  2'd0, 1'b1, 1'b0, 1'b0, 2'd3);
    push(b + 77,  2'd1, 1'b0, 1'b0, 1'b0, 2'd3);
    push(b + 109, 2'd0, 1'b1, 1'b0, 1'b0, 2'd3);
    push(b + 113, 2'd1, 1'b0, 1'b0, 1'b0, 2'd3);
    tick(1);
    sw_restart = 1'b0;
    tick(113);

    // Async reset in the middle of STABLE, between clock edges.
    pll_locked = 1'b1;
    push(b + 117, 2'd2, 1'b0, 1'b0, 1'b0, 2'd3);
    tick(6);
    #5;
    push(cyc, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    reset_n = 1'b0;
    #3;
    pll_locked = 1'b0;
    tick(5);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL events_pending: got %0d unseen expected events, required 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
